// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM arbiter: RAM status codes and arbiter FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        TURN    = 2'd3
    } arb_state_t;

    localparam logic LAST_GRANT_I = 1'b0;
    localparam logic LAST_GRANT_D = 1'b1;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Clear/enable counter of non-ACCESS grant cycles; tc flags the TIMEOUT-th such cycle.
module arb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // The arbiter aborts in the cycle that would make the count reach TIMEOUT.
    assign tc = en && (cnt == LAST);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single-port RAM between icache and dcache fill/writeback paths.
// Optional ARB_ROUND_ROBIN_EN alternates priority on simultaneous requests.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              timeout_err,
    output arb_state_t        state
);
    // Handshake: a cache holds its request and operands steady while its wait
    // is 1; wait drops for exactly the ACCESS cycle that completes the transfer.
    ramstate_t rs;
    logic      granted_req;
    logic      in_grant;
    logic      access;
    logic      tc;

    assign rs       = ramstate_t'(ramstate);
    assign in_grant = (state == GRANT_I) || (state == GRANT_D);
    assign access   = granted_req && (rs == ACCESS);

    always_comb begin
        granted_req = 1'b0;
        case (state)
            GRANT_I: granted_req = iREN;
            GRANT_D: granted_req = dREN || dWEN;
            default: granted_req = 1'b0;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            GRANT_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            GRANT_D: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

    assign iwait = !((state == GRANT_I) && access);
    assign dwait = !((state == GRANT_D) && access);
    assign iload = ramload;
    assign dload = ramload;

    arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
        .clk  (clk),
        .nRST (nRST),
        .clr  (!in_grant),
        .en   (in_grant && (rs != ACCESS)),
        .tc   (tc)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            timeout_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant  <= LAST_GRANT_I;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
                    if ((dREN || dWEN) && iREN) begin
                        // Whoever was not served last goes first.
                        if (last_grant == LAST_GRANT_I) begin
                            state      <= GRANT_D;
                            last_grant <= LAST_GRANT_D;
                        end else begin
                            state      <= GRANT_I;
                            last_grant <= LAST_GRANT_I;
                        end
                    end else if (dREN || dWEN) begin
                        state      <= GRANT_D;
                        last_grant <= LAST_GRANT_D;
                    end else if (iREN) begin
                        state      <= GRANT_I;
                        last_grant <= LAST_GRANT_I;
                    end
`else
                    if (dREN || dWEN) begin
                        state <= GRANT_D;
                    end else if (iREN) begin
                        state <= GRANT_I;
                    end
`endif
                end
                GRANT_I, GRANT_D: begin
                    if (!granted_req || access) begin
                        state <= TURN;
                    end else if (tc) begin
                        timeout_err <= 1'b1;
                        state       <= TURN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (built with TIMEOUT=4).
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    logic        clk = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, timeout_err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    arb_state_t  state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(32), .WORD_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .timeout_err(timeout_err), .state(state)
    );

    // Advance to the next falling edge, then let combinational outputs settle.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 32'h55AA_1234; ramstate = 2'd0;
        #12;
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", state, IDLE); end
        n_checks++; if ({iwait, dwait} !== 2'b11) begin n_fail++; $display("FAIL reset_waits got %b want 11", {iwait, dwait}); end
        n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL reset_enables got %b want 00", {ramREN, ramWEN}); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
        n_checks++; if (iload !== 32'h55AA_1234 || dload !== 32'h55AA_1234) begin n_fail++; $display("FAIL reset_passthrough got %h/%h want 55aa1234", iload, dload); end
        step(); nRST = 1'b1;
    endtask

    task automatic test_icache_only();
        step(); iREN = 1; iaddr = 32'h40; ramstate = FREE; settle();
        n_checks++; if (state !== IDLE || ramREN !== 1'b0) begin n_fail++; $display("FAIL ic_idle got state=%0d ren=%b want 0/0", state, ramREN); end
        step(); ramstate = BUSY; settle();
        n_checks++; if (state !== GRANT_I || ramREN !== 1'b1 || ramaddr !== 32'h40) begin n_fail++; $display("FAIL ic_grant got state=%0d ren=%b addr=%h want 1/1/40", state, ramREN, ramaddr); end
        n_checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin n_fail++; $display("FAIL ic_busy1_waits got %b%b want 11", iwait, dwait); end
        step(); settle();
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL ic_busy2_iwait got %b want 1", iwait); end
        step(); ramstate = ACCESS; ramload = 32'hDEAD_BEEF; settle();
        n_checks++; if (iwait !== 1'b0 || dwait !== 1'b1) begin n_fail++; $display("FAIL ic_access_waits got %b%b want 01", iwait, dwait); end
        n_checks++; if (iload !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ic_iload got %h want deadbeef", iload); end
        step(); iREN = 0; ramstate = FREE; settle();
        n_checks++; if (state !== TURN || iwait !== 1'b1 || ramREN !== 1'b0) begin n_fail++; $display("FAIL ic_turn got state=%0d iwait=%b ren=%b want 3/1/0", state, iwait, ramREN); end
        step(); settle();
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL ic_back_idle got %0d want 0", state); end
    endtask

    task automatic test_simultaneous();
        step(); iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234_5678; settle();
        step(); ramstate = BUSY; settle();
        n_checks++; if (state !== GRANT_D || ramWEN !== 1'b1 || ramREN !== 1'b0) begin n_fail++; $display("FAIL sim_dgrant got state=%0d wen=%b ren=%b want 2/1/0", state, ramWEN, ramREN); end
        n_checks++; if (ramaddr !== 32'h80 || ramstore !== 32'h1234_5678) begin n_fail++; $display("FAIL sim_daddr got %h/%h want 80/12345678", ramaddr, ramstore); end
        step(); ramstate = ACCESS; settle();
        n_checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL sim_daccess got d=%b i=%b want 0/1", dwait, iwait); end
        step(); dWEN = 0; ramstate = FREE; settle();
        n_checks++; if (state !== TURN || ramWEN !== 1'b0) begin n_fail++; $display("FAIL sim_turn got state=%0d wen=%b want 3/0", state, ramWEN); end
        step(); settle();
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL sim_idle got %0d want 0", state); end
        step(); ramstate = ACCESS; ramload = 32'hCAFE_F00D; settle();
        n_checks++; if (state !== GRANT_I || ramaddr !== 32'h44 || iwait !== 1'b0 || iload !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL sim_igrant got state=%0d addr=%h iwait=%b load=%h want 1/44/0/cafef00d", state, ramaddr, iwait, iload); end
        step(); iREN = 0; ramstate = FREE; settle();
        step(); settle();
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL sim_end_idle got %0d want 0", state); end
    endtask

    task automatic test_no_preemption();
        step(); iREN = 1; iaddr = 32'h100; settle();
        step(); dREN = 1; daddr = 32'h200; ramstate = BUSY; settle();
        n_checks++; if (state !== GRANT_I || ramaddr !== 32'h100 || dwait !== 1'b1) begin n_fail++; $display("FAIL np_hold1 got state=%0d addr=%h dwait=%b want 1/100/1", state, ramaddr, dwait); end
        step(); settle();
        n_checks++; if (state !== GRANT_I || ramaddr !== 32'h100 || ramREN !== 1'b1) begin n_fail++; $display("FAIL np_hold2 got state=%0d addr=%h ren=%b want 1/100/1", state, ramaddr, ramREN); end
        step(); ramstate = ACCESS; ramload = 32'h1111_2222; settle();
        n_checks++; if (iwait !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'h100) begin n_fail++; $display("FAIL np_iaccess got i=%b d=%b addr=%h want 0/1/100", iwait, dwait, ramaddr); end
        step(); iREN = 0; ramstate = FREE; settle();
        step(); settle();
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL np_idle got %0d want 0", state); end
        step(); ramstate = ACCESS; ramload = 32'h3333_4444; settle();
        n_checks++; if (state !== GRANT_D || ramaddr !== 32'h200 || ramREN !== 1'b1 || dwait !== 1'b0 || dload !== 32'h3333_4444) begin n_fail++; $display("FAIL np_dserve got state=%0d addr=%h ren=%b dwait=%b load=%h want 2/200/1/0/33334444", state, ramaddr, ramREN, dwait, dload); end
        step(); dREN = 0; ramstate = FREE; settle();
        step(); settle();
    endtask

    task automatic test_requester_drop();
        step(); dREN = 1; daddr = 32'h300; settle();
        step(); ramstate = BUSY; settle();
        n_checks++; if (state !== GRANT_D) begin n_fail++; $display("FAIL drop_grant got %0d want 2", state); end
        step(); dREN = 0; ramstate = ACCESS; settle();
        n_checks++; if (dwait !== 1'b1 || ramREN !== 1'b0) begin n_fail++; $display("FAIL drop_nodata got dwait=%b ren=%b want 1/0", dwait, ramREN); end
        step(); ramstate = FREE; settle();
        n_checks++; if (state !== TURN) begin n_fail++; $display("FAIL drop_turn got %0d want 3", state); end
        step(); settle();
    endtask

    task automatic test_timeout();
        step(); iREN = 1; iaddr = 32'h500; ramstate = FREE; settle();
        for (int k = 0; k < 4; k++) begin
            step(); ramstate = (k == 2) ? ERROR : BUSY; settle();
            n_checks++; if (state !== GRANT_I || iwait !== 1'b1 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d got state=%0d iwait=%b err=%b want 1/1/0", k, state, iwait, timeout_err); end
        end
        step(); iREN = 0; ramstate = FREE; settle();
        n_checks++; if (state !== TURN || timeout_err !== 1'b1 || iwait !== 1'b1) begin n_fail++; $display("FAIL to_abort got state=%0d err=%b iwait=%b want 3/1/1", state, timeout_err, iwait); end
        step(); settle();
        n_checks++; if (state !== IDLE || timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_idle got state=%0d err=%b want 0/1", state, timeout_err); end
        step(); iREN = 1; settle();
        step(); ramstate = ACCESS; settle();
        n_checks++; if (iwait !== 1'b0) begin n_fail++; $display("FAIL to_retry got iwait=%b want 0", iwait); end
        step(); iREN = 0; ramstate = FREE; settle();
        step(); settle();
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        step(); dREN = 1; daddr = 32'h600; settle();
        step(); ramstate = BUSY; settle();
        n_checks++; if (state !== GRANT_D || ramREN !== 1'b1) begin n_fail++; $display("FAIL rm_grant got state=%0d ren=%b want 2/1", state, ramREN); end
        #1 nRST = 1'b0; #1;
        n_checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || state !== IDLE || dwait !== 1'b1) begin n_fail++; $display("FAIL rm_async got ren=%b wen=%b state=%0d dwait=%b want 0/0/0/1", ramREN, ramWEN, state, dwait); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rm_err_clear got %b want 0", timeout_err); end
        dREN = 0; ramstate = FREE;
        step(); nRST = 1'b1;
        step(); settle();
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL rm_idle got %0d want 0", state); end
    endtask

    task automatic test_arbitration_order();
        logic [1:0] exp_q[$];
        logic [1:0] want;
        int         seen = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_q = '{GRANT_D, GRANT_I, GRANT_D, GRANT_I};
`else
        exp_q = '{GRANT_D, GRANT_D, GRANT_D, GRANT_D};
`endif
        step(); iREN = 1; dREN = 1; ramstate = ACCESS; settle();
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            step(); settle();
            if (state == GRANT_I || state == GRANT_D) begin
                want = exp_q.pop_front();
                n_checks++; if (state !== want) begin n_fail++; $display("FAIL order_grant%0d got %0d want %0d", seen, state, want); end
                seen++;
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL order_budget got %0d grants want 4", seen); end
        iREN = 0; dREN = 0; ramstate = FREE;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_icache_only();
        test_simultaneous();
        test_no_preemption();
        test_requester_drop();
        test_timeout();
        test_reset_mid();
        test_arbitration_order();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
